id_operand_stage: RTL and testbench

//  Decode-to-execute operand stage of the LA32R pipeline. Drives the register file read ports,

---
 rtl/id_operand_stage.sv | 118 +++++++++++
 tb/tb_id_operand_stage.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_operand_stage.sv
// Decode-to-execute operand stage: register read, EX/MEM/WB bypass, RAW hazard
// detection and a valid/ready output register toward EX.
module id_operand_stage #(
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   flush,
  input  logic                   if_valid,
  output logic                   if_ready,
  input  logic [31:0]            if_pc,
  input  logic [4:0]             if_ra0,
  input  logic [4:0]             if_ra1,
  input  logic                   if_use0,
  input  logic                   if_use1,
  input  logic [4:0]             if_wa,
  input  logic                   if_we,
  input  logic                   if_is_load,
  output logic [4:0]             rf_ra0,
  output logic [4:0]             rf_ra1,
  input  logic [31:0]            rf_rd0,
  input  logic [31:0]            rf_rd1,
  input  logic                   ex_we,
  input  logic [4:0]             ex_wa,
  input  logic [31:0]            ex_wd,
  input  logic                   ex_is_load,
  input  logic                   mem_we,
  input  logic [4:0]             mem_wa,
  input  logic [31:0]            mem_wd,
  input  logic                   wb_we,
  input  logic [4:0]             wb_wa,
  input  logic [31:0]            wb_wd,
  output logic                   id_valid,
  input  logic                   id_ready,
  output logic [31:0]            id_pc,
  output logic [31:0]            id_op0,
  output logic [31:0]            id_op1,
  output logic [4:0]             id_wa,
  output logic                   id_we,
  output logic                   id_is_load,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic        live0, live1;
  logic        hazard, accept;
  logic [31:0] op0, op1;

  assign rf_ra0 = if_ra0;
  assign rf_ra1 = if_ra1;

  assign live0 = if_use0 && (if_ra0 != 5'd0);
  assign live1 = if_use1 && (if_ra1 != 5'd0);

  // A load in EX has no data yet, so it stalls instead of forwarding.
  assign hazard =
      (live0 && id_valid && id_we && (id_wa == if_ra0)) ||
      (live1 && id_valid && id_we && (id_wa == if_ra1)) ||
      (live0 && ex_we && ex_is_load && (ex_wa == if_ra0)) ||
      (live1 && ex_we && ex_is_load && (ex_wa == if_ra1));

  assign if_ready = !flush && !hazard && (!id_valid || id_ready);
  assign accept   = if_valid && if_ready;

  always_comb begin
    op0 = rf_rd0;
    if (if_ra0 == 5'd0) begin
      op0 = '0;
    end else if (live0) begin
      if (ex_we && !ex_is_load && (ex_wa == if_ra0))  op0 = ex_wd;
      else if (mem_we && (mem_wa == if_ra0))           op0 = mem_wd;
      else if (wb_we && (wb_wa == if_ra0))             op0 = wb_wd;
    end
  end

  always_comb begin
    op1 = rf_rd1;
    if (if_ra1 == 5'd0) begin
      op1 = '0;
    end else if (live1) begin
      if (ex_we && !ex_is_load && (ex_wa == if_ra1))  op1 = ex_wd;
      else if (mem_we && (mem_wa == if_ra1))           op1 = mem_wd;
      else if (wb_we && (wb_wa == if_ra1))             op1 = wb_wd;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      id_valid   <= 1'b0;
      id_pc      <= '0;
      id_op0     <= '0;
      id_op1     <= '0;
      id_wa      <= '0;
      id_we      <= 1'b0;
      id_is_load <= 1'b0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (accept) begin
      id_valid   <= 1'b1;
      id_pc      <= if_pc;
      id_op0     <= op0;
      id_op1     <= op1;
      id_wa      <= if_wa;
      id_we      <= if_we;
      id_is_load <= if_is_load;
    end else if (id_ready) begin
      id_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= '0;
    end else if (if_valid && hazard && !flush && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench for id_operand_stage: forwarding vector table plus
// hand-written load-use, dependency, backpressure, flush, saturation and reset sequences.
module tb_id_operand_stage;
  localparam int SW = 3;
  localparam int SAT = (1 << SW) - 1;

  logic clk = 1'b0, rstn = 1'b0, flush = 1'b0;
  logic if_valid = 1'b0, if_ready;
  logic [31:0] if_pc = '0;
  logic [4:0] if_ra0 = '0, if_ra1 = '0, if_wa = '0;
  logic if_use0 = 1'b0, if_use1 = 1'b0, if_we = 1'b0, if_is_load = 1'b0;
  logic [4:0] rf_ra0, rf_ra1;
  logic [31:0] rf_rd0 = '0, rf_rd1 = '0;
  logic ex_we = 1'b0, ex_is_load = 1'b0, mem_we = 1'b0, wb_we = 1'b0;
  logic [4:0] ex_wa = '0, mem_wa = '0, wb_wa = '0;
  logic [31:0] ex_wd = '0, mem_wd = '0, wb_wd = '0;
  logic id_valid, id_ready = 1'b1;
  logic [31:0] id_pc, id_op0, id_op1;
  logic [4:0] id_wa;
  logic id_we, id_is_load;
  logic [SW-1:0] stall_cnt;

  id_operand_stage #(.STALL_CNT_W(SW)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
    .if_ra0(if_ra0), .if_ra1(if_ra1), .if_use0(if_use0), .if_use1(if_use1),
    .if_wa(if_wa), .if_we(if_we), .if_is_load(if_is_load),
    .rf_ra0(rf_ra0), .rf_ra1(rf_ra1), .rf_rd0(rf_rd0), .rf_rd1(rf_rd1),
    .ex_we(ex_we), .ex_wa(ex_wa), .ex_wd(ex_wd), .ex_is_load(ex_is_load),
    .mem_we(mem_we), .mem_wa(mem_wa), .mem_wd(mem_wd),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_op0(id_op0), .id_op1(id_op1), .id_wa(id_wa), .id_we(id_we),
    .id_is_load(id_is_load), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] ra0; logic use0; logic [31:0] rd0;
    logic [4:0] ra1; logic use1; logic [31:0] rd1;
    logic exw; logic [4:0] exa; logic [31:0] exd; logic exl;
    logic mw; logic [4:0] ma; logic [31:0] md;
    logic ww; logic [4:0] wba; logic [31:0] wd;
    logic rdy; logic [31:0] e0; logic [31:0] e1;
  } vec_t;

  typedef struct {
    logic [31:0] pc; logic [31:0] op0; logic [31:0] op1;
    logic [4:0] wa; logic we; logic ld;
  } exp_t;

  exp_t sb[$];
  vec_t v[12];
  int n_checks = 0, n_fail = 0;
  int exp_stall = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bump_stall();
    if (exp_stall < SAT) exp_stall++;
  endtask

  task automatic clear_fwd();
    ex_we = 0; ex_wa = 0; ex_wd = 0; ex_is_load = 0;
    mem_we = 0; mem_wa = 0; mem_wd = 0;
    wb_we = 0; wb_wa = 0; wb_wd = 0;
  endtask

  task automatic drive_if(input logic [31:0] pc, input logic [4:0] ra0, input logic use0,
                          input logic [4:0] ra1, input logic use1,
                          input logic [4:0] wa, input logic we, input logic ld);
    if_valid = 1; if_pc = pc; if_ra0 = ra0; if_use0 = use0; if_ra1 = ra1; if_use1 = use1;
    if_wa = wa; if_we = we; if_is_load = ld;
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] o0, input logic [31:0] o1,
                          input logic [4:0] wa, input logic we, input logic ld);
    exp_t e;
    e.pc = pc; e.op0 = o0; e.op1 = o1; e.wa = wa; e.we = we; e.ld = ld;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s: scoreboard empty, got id_valid=%0b expected a queued entry", name, id_valid);
    end else begin
      e = sb.pop_front();
      chk({name, "_valid"}, 32'(id_valid), 32'd1);
      chk({name, "_pc"}, id_pc, e.pc);
      chk({name, "_op0"}, id_op0, e.op0);
      chk({name, "_op1"}, id_op1, e.op1);
      chk({name, "_dst"}, {25'd0, id_wa, id_we, id_is_load}, {25'd0, e.wa, e.we, e.ld});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    v[0]  = '{5'd5, 1'b1, 32'h11,   5'd0, 1'b0, 32'hDEAD, 1'b0, 5'd0, 32'h0, 1'b0,
              1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 32'h11, 32'h0};
    v[1]  = '{5'd3, 1'b1, 32'hD,    5'd0, 1'b0, 32'h0,  1'b1, 5'd3, 32'hA, 1'b0,
              1'b1, 5'd3, 32'hB,  1'b1, 5'd3, 32'hC,  1'b1, 32'hA, 32'h0};
    v[2]  = '{5'd3, 1'b1, 32'hD,    5'd0, 1'b0, 32'h0,  1'b0, 5'd3, 32'hA, 1'b0,
              1'b1, 5'd3, 32'hB,  1'b1, 5'd3, 32'hC,  1'b1, 32'hB, 32'h0};
    v[3]  = '{5'd3, 1'b1, 32'hD,    5'd0, 1'b0, 32'h0,  1'b0, 5'd0, 32'h0, 1'b0,
              1'b0, 5'd3, 32'hB,  1'b1, 5'd3, 32'hC,  1'b1, 32'hC, 32'h0};
    v[4]  = '{5'd3, 1'b1, 32'hD,    5'd0, 1'b0, 32'h0,  1'b0, 5'd0, 32'h0, 1'b0,
              1'b0, 5'd0, 32'h0,  1'b1, 5'd4, 32'hC,  1'b1, 32'hD, 32'h0};
    v[5]  = '{5'd0, 1'b1, 32'h1234, 5'd0, 1'b0, 32'h0,  1'b1, 5'd0, 32'hFF, 1'b0,
              1'b1, 5'd0, 32'hBB, 1'b0, 5'd0, 32'h0,  1'b1, 32'h0, 32'h0};
    v[6]  = '{5'd0, 1'b0, 32'h0,    5'd4, 1'b1, 32'h44, 1'b1, 5'd4, 32'hEE, 1'b1,
              1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 32'h0, 32'h0};
    v[7]  = '{5'd7, 1'b0, 32'h55,   5'd0, 1'b0, 32'h0,  1'b1, 5'd7, 32'hEE, 1'b1,
              1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 32'h55, 32'h0};
    v[8]  = '{5'd6, 1'b1, 32'h6,    5'd9, 1'b1, 32'h9,  1'b1, 5'd9, 32'h99, 1'b0,
              1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'h0,  1'b1, 32'h66, 32'h99};
    v[9]  = '{5'd10, 1'b1, 32'h10,  5'd0, 1'b0, 32'h0,  1'b0, 5'd10, 32'hAA, 1'b0,
              1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 32'h10, 32'h0};
    v[10] = '{5'd12, 1'b1, 32'h0,   5'd0, 1'b0, 32'h0,  1'b1, 5'd12, 32'h12, 1'b1,
              1'b1, 5'd12, 32'h34, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0};
    v[11] = '{5'd0, 1'b0, 32'h0,    5'd2, 1'b1, 32'h2,  1'b0, 5'd0, 32'h0, 1'b0,
              1'b0, 5'd0, 32'h0,  1'b1, 5'd2, 32'h22, 1'b1, 32'h0, 32'h22};

    // reset values, no clock edge yet
    #2;
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_fields", id_pc | id_op0 | id_op1 | 32'(id_wa) | 32'(id_we) | 32'(id_is_load), 32'd0);
    #10 rstn = 1;
    tick();

    // forwarding / hazard table
    for (int i = 0; i < 12; i++) begin
      clear_fwd();
      rf_rd0 = v[i].rd0; rf_rd1 = v[i].rd1;
      ex_we = v[i].exw; ex_wa = v[i].exa; ex_wd = v[i].exd; ex_is_load = v[i].exl;
      mem_we = v[i].mw; mem_wa = v[i].ma; mem_wd = v[i].md;
      wb_we = v[i].ww; wb_wa = v[i].wba; wb_wd = v[i].wd;
      drive_if(32'h1000 + 32'(i * 4), v[i].ra0, v[i].use0, v[i].ra1, v[i].use1, 5'd1, 1'b0, 1'b0);
      id_ready = 1;
      #1;
      chk("vec_ready", 32'(if_ready), 32'(v[i].rdy));
      chk("vec_rf_ra", {22'd0, rf_ra0, rf_ra1}, {22'd0, v[i].ra0, v[i].ra1});
      if (v[i].rdy) push_exp(if_pc, v[i].e0, v[i].e1, 5'd1, 1'b0, 1'b0);
      else bump_stall();
      tick();
      if_valid = 0;
      if (v[i].rdy) pop_check("vec");
      else chk("vec_novalid", 32'(id_valid), 32'd0);
      chk("vec_stall", 32'(stall_cnt), 32'(exp_stall));
    end

    // load-use: stall one cycle, then MEM supplies the loaded value
    clear_fwd();
    ex_we = 1; ex_wa = 4; ex_wd = 32'hBAD; ex_is_load = 1;
    rf_rd0 = 32'h4; rf_rd1 = 0;
    drive_if(32'h2000, 5'd4, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    #1;
    chk("lu_ready0", 32'(if_ready), 32'd0);
    bump_stall();
    tick();
    chk("lu_stall", 32'(stall_cnt), 32'(exp_stall));
    clear_fwd();
    mem_we = 1; mem_wa = 4; mem_wd = 32'h77;
    #1;
    chk("lu_ready1", 32'(if_ready), 32'd1);
    push_exp(32'h2000, 32'h77, 32'h0, 5'd9, 1'b1, 1'b0);
    tick();
    if_valid = 0;
    pop_check("lu");

    // back-to-back dependency on the instruction held in ID
    clear_fwd();
    rf_rd1 = 32'h9;
    drive_if(32'h2004, 5'd0, 1'b0, 5'd9, 1'b1, 5'd3, 1'b0, 1'b1);
    #1;
    chk("dep_ready0", 32'(if_ready), 32'd0);
    bump_stall();
    tick();
    chk("dep_stall", 32'(stall_cnt), 32'(exp_stall));
    ex_we = 1; ex_wa = 9; ex_wd = 32'h99;
    #1;
    chk("dep_ready1", 32'(if_ready), 32'd1);
    push_exp(32'h2004, 32'h0, 32'h99, 5'd3, 1'b0, 1'b1);
    tick();
    pop_check("dep");

    // backpressure: id_* held for three cycles while upstream keeps changing
    id_ready = 0;
    for (int k = 0; k < 3; k++) begin
      clear_fwd();
      ex_we = 1; ex_wa = 9; ex_wd = 32'h500 + 32'(k);
      rf_rd0 = 32'h600 + 32'(k); rf_rd1 = 32'h700 + 32'(k);
      drive_if(32'h3000 + 32'(k), 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
      #1;
      chk("bp_ready", 32'(if_ready), 32'd0);
      tick();
      chk("bp_valid", 32'(id_valid), 32'd1);
      chk("bp_pc", id_pc, 32'h2004);
      chk("bp_op1", id_op1, 32'h99);
    end
    chk("bp_stall", 32'(stall_cnt), 32'(exp_stall));

    // flush drops the held instruction
    clear_fwd();
    flush = 1;
    tick();
    chk("fl_valid", 32'(id_valid), 32'd0);

    // flush beats a would-be accept and a hazard stall
    id_ready = 1;
    drive_if(32'h3100, 5'd1, 1'b1, 5'd0, 1'b0, 5'd1, 1'b0, 1'b0);
    #1;
    chk("fl_acc_ready", 32'(if_ready), 32'd0);
    tick();
    chk("fl_acc_valid", 32'(id_valid), 32'd0);
    ex_we = 1; ex_wa = 1; ex_is_load = 1;
    tick();
    chk("fl_haz_stall", 32'(stall_cnt), 32'(exp_stall));
    flush = 0;

    // saturation of the stall counter under a persistent load-use hazard
    for (int k = 0; k < 6; k++) begin
      bump_stall();
      tick();
      chk("sat_stall", 32'(stall_cnt), 32'(exp_stall));
    end

    // async reset mid-handshake
    clear_fwd();
    id_ready = 0;
    drive_if(32'h4000, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0);
    tick();
    chk("ar_valid_pre", 32'(id_valid), 32'd1);
    #2 rstn = 0;
    #1;
    chk("ar_valid", 32'(id_valid), 32'd0);
    chk("ar_stall", 32'(stall_cnt), 32'd0);
    chk("ar_pc", id_pc, 32'd0);
    exp_stall = 0;
    #2 rstn = 1;
    if_valid = 0;
    tick();
    chk("ar_after", 32'(id_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
